// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared widths and 2-bit branch-history counter definitions for the fetch PC sequencer.
package fetch_pc_sequencer_pkg;

  localparam int XLEN     = 32;
  localparam int PC_WIDTH = 32;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_ctr_e;

  // Saturating step of one counter toward the resolved outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == BHT_ST) ? ctr : ctr + 2'd1;
    end
    return (ctr == BHT_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read, synchronous train.
module bht_2bit
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] BHT_INIT  = BHT_WNT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BHT_IDX_W-1:0] rd_idx_i,
  output logic [1:0]           rd_ctr_o,
  input  logic                 train_valid_i,
  input  logic [BHT_IDX_W-1:0] train_idx_i,
  input  logic                 train_taken_i
);

  localparam int ENTRIES = 1 << BHT_IDX_W;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  always_comb begin
    ctr_d = ctr_q;
    if (train_valid_i) begin
      ctr_d[train_idx_i] = bht_next(ctr_q[train_idx_i], train_taken_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Read returns the registered value, so a same-cycle train is seen one cycle later.
  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register: BHT-assisted next-PC prediction with trap/mispredict override.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter int                  BHT_IDX_W = 6,
  parameter logic [1:0]          BHT_INIT  = BHT_WNT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                F_stall_i,
  input  logic                mini_op_branch_i,
  input  logic                mini_op_jal_i,
  input  logic [PC_WIDTH-1:0] mini_jal_jmp_i,
  input  logic [PC_WIDTH-1:0] mini_branch_jmp_i,
  input  logic                E_redirect_i,
  input  logic [PC_WIDTH-1:0] E_redirect_pc_i,
  input  logic                E_train_valid_i,
  input  logic [PC_WIDTH-1:0] E_train_pc_i,
  input  logic                E_train_taken_i,
  input  logic                C_trap_i,
  input  logic [PC_WIDTH-1:0] C_trap_pc_i,
  output logic [PC_WIDTH-1:0] F_PC_o,
  output logic                F_pred_taken_o,
  output logic [PC_WIDTH-1:0] F_pred_target_o,
  output logic                FD_flush_o,
  output logic [XLEN-1:0]     mispred_cnt_o
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     mispred_cnt_q, mispred_cnt_d;
  logic [1:0]          bht_rd_ctr;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_target;
  logic                unused_train_pc_bits;

  assign unused_train_pc_bits = ^{E_train_pc_i[PC_WIDTH-1:BHT_IDX_W+2], E_train_pc_i[1:0]};

  bht_2bit #(
    .BHT_IDX_W (BHT_IDX_W),
    .BHT_INIT  (BHT_INIT)
  ) u_bht (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rd_idx_i      (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr_o      (bht_rd_ctr),
    .train_valid_i (E_train_valid_i),
    .train_idx_i   (E_train_pc_i[BHT_IDX_W+1:2]),
    .train_taken_i (E_train_taken_i)
  );

  always_comb begin
    pred_taken = mini_op_jal_i | (mini_op_branch_i & bht_rd_ctr[1]);
    if (mini_op_jal_i) begin
      pred_target = mini_jal_jmp_i;
    end else if (pred_taken) begin
      pred_target = mini_branch_jmp_i;
    end else begin
      pred_target = pc_q + 32'd4;
    end

    // Redirects land regardless of stall; trap outranks mispredict.
    pc_d = pred_target;
    if (C_trap_i) begin
      pc_d = C_trap_pc_i;
    end else if (E_redirect_i) begin
      pc_d = E_redirect_pc_i;
    end else if (F_stall_i) begin
      pc_d = pc_q;
    end

    flush_d       = C_trap_i | E_redirect_i;
    mispred_cnt_d = mispred_cnt_q + {{(XLEN-1){1'b0}}, E_redirect_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign F_PC_o          = pc_q;
  assign F_pred_taken_o  = pred_taken;
  assign F_pred_target_o = pred_target;
  assign FD_flush_o      = flush_q;
  assign mispred_cnt_o   = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: per-cycle reference model plus hand-computed checkpoints.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br, jal;
  logic [31:0] jal_jmp, br_jmp;
  logic        redir;
  logic [31:0] redir_pc;
  logic        tr_valid, tr_taken;
  logic [31:0] tr_pc;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] f_pc, f_tgt, mis_cnt;
  logic        f_taken, flush;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  int exp_redirs = 0;

  // Reference state: plain integers, updated from the rules at each rising edge
  logic [31:0] m_pc, m_cnt;
  logic        m_flush;
  int          m_bht [64];

  fetch_pc_sequencer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .F_stall_i         (stall),
    .mini_op_branch_i  (br),
    .mini_op_jal_i     (jal),
    .mini_jal_jmp_i    (jal_jmp),
    .mini_branch_jmp_i (br_jmp),
    .E_redirect_i      (redir),
    .E_redirect_pc_i   (redir_pc),
    .E_train_valid_i   (tr_valid),
    .E_train_pc_i      (tr_pc),
    .E_train_taken_i   (tr_taken),
    .C_trap_i          (trap),
    .C_trap_pc_i       (trap_pc),
    .F_PC_o            (f_pc),
    .F_pred_taken_o    (f_taken),
    .F_pred_target_o   (f_tgt),
    .FD_flush_o        (flush),
    .mispred_cnt_o     (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bidx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic m_taken();
    return jal || (br && m_bht[bidx(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target();
    if (jal) return jal_jmp;
    if (m_taken()) return br_jmp;
    return m_pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model_upd
    logic [31:0] tgt;
    int          i;
    if (rst) begin
      m_pc    = RESET_PC;
      m_flush = 1'b0;
      m_cnt   = 32'd0;
      for (int k = 0; k < 64; k++) m_bht[k] = 1;
    end else begin
      tgt = m_target();
      if (trap)        m_pc = trap_pc;
      else if (redir)  m_pc = redir_pc;
      else if (!stall) m_pc = tgt;
      m_flush = trap | redir;
      m_cnt   = m_cnt + (redir ? 32'd1 : 32'd0);
      if (tr_valid) begin
        i = bidx(tr_pc);
        if (tr_taken) m_bht[i] = (m_bht[i] >= 3) ? 3 : m_bht[i] + 1;
        else          m_bht[i] = (m_bht[i] <= 0) ? 0 : m_bht[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", f_pc, m_pc);
      check("model_pred_taken", f_taken, m_taken());
      check("model_pred_target", f_tgt, m_target());
      check("model_flush", flush, m_flush);
      check("model_mispred_cnt", mis_cnt, m_cnt);
    end
  end

  task automatic idle();
    stall = 0; br = 0; jal = 0; jal_jmp = '0; br_jmp = '0;
    redir = 0; redir_pc = '0; tr_valid = 0; tr_pc = '0; tr_taken = 0;
    trap = 0; trap_pc = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir = 1; redir_pc = pc; exp_redirs++;
    cyc();
    redir = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    check("reset_pc0", f_pc, 32'h8000_0000);
    check("reset_flush", flush, 1'b0);
    check("reset_cnt", mis_cnt, 32'd0);
    cyc(); check("seq_pc4", f_pc, 32'h8000_0004);
    cyc(); check("seq_pc8", f_pc, 32'h8000_0008);
    cyc(); cyc(); check("seq_pc10", f_pc, 32'h8000_0010);

    // jal, then a 3-cycle stall
    jal = 1; jal_jmp = 32'h8000_0100; #1;
    check("jal_target", f_tgt, 32'h8000_0100);
    cyc(); jal = 0;
    check("jal_pc", f_pc, 32'h8000_0100);
    stall = 1;
    for (int s = 0; s < 3; s++) begin
      cyc(); check("stall_hold", f_pc, 32'h8000_0100);
    end
    stall = 0;

    // Train taken twice: 01 -> 10 -> 11
    tr_valid = 1; tr_pc = 32'h8000_0020; tr_taken = 1;
    cyc(); cyc();
    tr_valid = 0;
    redirect_to(32'h8000_0020);
    check("redir_pc20", f_pc, 32'h8000_0020);
    check("redir_flush", flush, 1'b1);
    br = 1; br_jmp = 32'h8000_0080; #1;
    check("bht11_taken", f_taken, 1'b1);
    cyc(); br = 0;
    check("bht11_next", f_pc, 32'h8000_0080);

    // Train not-taken twice: 11 -> 10 -> 01
    tr_valid = 1; tr_taken = 0;
    cyc(); cyc();
    tr_valid = 0;
    redirect_to(32'h8000_0020);
    br = 1; #1;
    check("bht01_not_taken", f_taken, 1'b0);
    cyc(); br = 0;
    check("bht01_next", f_pc, 32'h8000_0024);

    // Two more not-taken saturate at 00, one taken brings it to 01
    tr_valid = 1; tr_taken = 0;
    cyc(); cyc();
    tr_taken = 1;
    cyc();
    tr_valid = 0;
    redirect_to(32'h8000_0020);
    br = 1; #1;
    check("bht_sat_low", f_taken, 1'b0);
    cyc(); br = 0;

    // Collision: entry 01 trained taken while fetch reads it
    redirect_to(32'h8000_0020);
    br = 1; tr_valid = 1; tr_taken = 1; #1;
    check("collision_old", f_taken, 1'b0);
    cyc(); br = 0; tr_valid = 0;
    check("collision_next", f_pc, 32'h8000_0024);
    redirect_to(32'h8000_0020);
    br = 1; #1;
    check("collision_new", f_taken, 1'b1);
    cyc(); br = 0;
    check("collision_pc", f_pc, 32'h8000_0080);

    // Trap and mispredict together under stall: trap wins, both counted/flushed once
    stall = 1; trap = 1; trap_pc = 32'h8000_0200;
    redirect_to(32'h8000_0300);
    stall = 0; trap = 0;
    check("prio_pc", f_pc, 32'h8000_0200);
    check("prio_flush", flush, 1'b1);
    check("prio_cnt", mis_cnt, exp_redirs);
    cyc();
    check("prio_flush_end", flush, 1'b0);
    check("prio_pc_next", f_pc, 32'h8000_0204);

    // Back-to-back redirects to the top of the address space, then wrap
    redirect_to(32'hFFFF_FFFC);
    check("b2b_flush1", flush, 1'b1);
    redirect_to(32'hFFFF_FFFC);
    check("b2b_flush2", flush, 1'b1);
    check("wrap_pc", f_pc, 32'hFFFF_FFFC);
    check("wrap_target", f_tgt, 32'h0000_0000);
    cyc();
    check("wrap_next", f_pc, 32'h0000_0000);
    check("wrap_flush", flush, 1'b0);
    check("wrap_cnt", mis_cnt, exp_redirs);

    // Mid-run reset together with training
    tr_valid = 1; tr_pc = 32'h8000_0020; tr_taken = 1;
    cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0; tr_valid = 0;
    exp_redirs = 0;
    check("rst_pc", f_pc, RESET_PC);
    check("rst_flush", flush, 1'b0);
    check("rst_cnt", mis_cnt, 32'd0);
    redirect_to(32'h8000_0020);
    br = 1; br_jmp = 32'h8000_0080; #1;
    check("rst_bht_init", f_taken, 1'b0);
    cyc(); br = 0;
    check("rst_bht_next", f_pc, 32'h8000_0024);
    check("rst_cnt_after", mis_cnt, exp_redirs);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
